// File: rtl/csr_timer_bank_if.sv
// CSR access bus for the timer bank: combinational read port plus masked write port.
interface csr_timer_bank_if;
   logic        csr_re;
   logic [13:0] csr_num;
   logic [31:0] csr_rvalue;
   logic        csr_we;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;

   modport master (
      output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
      input  csr_rvalue
   );

   modport slave (
      input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
      output csr_rvalue
   );
endinterface

// File: rtl/csr_timer_bank.sv
// Bank of NUM_TIMERS down-counting timers with one-shot/periodic modes, CSR mapped,
// sticky per-channel pending bits and masked interrupt outputs.
module csr_timer_bank #(
   parameter int          NUM_TIMERS = 4,
   parameter logic [13:0] CSR_BASE   = 14'h060
) (
   input  logic                  clk,
   input  logic                  resetn,
   csr_timer_bank_if.slave       csr,
   input  logic                  freeze,
   output logic [NUM_TIMERS-1:0] timer_irq,
   output logic                  irq_any
);

   localparam logic [13:0] TIE_ADDR = CSR_BASE + 14'(3 * NUM_TIMERS);
   localparam logic [13:0] TIS_ADDR = TIE_ADDR + 14'd1;

   function automatic logic [13:0] cfg_addr(input int i);
      return CSR_BASE + 14'(3 * i);
   endfunction

   logic [31:0]           cfg [NUM_TIMERS];
   logic [31:0]           cnt [NUM_TIMERS];
   logic [31:0]           cfg_nxt [NUM_TIMERS];
   logic [NUM_TIMERS-1:0] cfg_wr;
   logic [NUM_TIMERS-1:0] clr_req;
   logic [NUM_TIMERS-1:0] tie;
   logic [NUM_TIMERS-1:0] pending;
   logic                  tie_wr;
   logic                  unused_re;

   // Read enable has no side effects; read data is always driven.
   assign unused_re = csr.csr_re;

   always_comb begin
      tie_wr = csr.csr_we && (csr.csr_num == TIE_ADDR);
      for (int i = 0; i < NUM_TIMERS; i++) begin
         cfg_wr[i]  = csr.csr_we && (csr.csr_num == cfg_addr(i));
         cfg_nxt[i] = (csr.csr_wmask & csr.csr_wvalue) | (~csr.csr_wmask & cfg[i]);
         clr_req[i] = csr.csr_we && (csr.csr_num == cfg_addr(i) + 14'd2)
                      && csr.csr_wmask[0] && csr.csr_wvalue[0];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tie     <= '0;
         pending <= '0;
         for (int i = 0; i < NUM_TIMERS; i++) begin
            cfg[i] <= '0;
            cnt[i] <= '1;
         end
      end else begin
         if (tie_wr)
            tie <= (csr.csr_wmask[NUM_TIMERS-1:0] & csr.csr_wvalue[NUM_TIMERS-1:0])
                 | (~csr.csr_wmask[NUM_TIMERS-1:0] & tie);
         for (int i = 0; i < NUM_TIMERS; i++) begin
            // A config write either loads the counter (en set) or freezes it in place.
            if (cfg_wr[i]) begin
               cfg[i] <= cfg_nxt[i];
               if (cfg_nxt[i][0])
                  cnt[i] <= {cfg_nxt[i][31:2], 2'b00};
            end else if (cfg[i][0] && !freeze && (cnt[i] != 32'hFFFF_FFFF)) begin
               if ((cnt[i] == 32'd0) && cfg[i][1])
                  cnt[i] <= {cfg[i][31:2], 2'b00};
               else
                  cnt[i] <= cnt[i] - 32'd1;
            end
            // Expiry beats a simultaneous software clear.
            if (cnt[i] == 32'd0)
               pending[i] <= 1'b1;
            else if (clr_req[i])
               pending[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      csr.csr_rvalue = 32'd0;
      if (csr.csr_num == TIE_ADDR)
         csr.csr_rvalue = 32'(tie);
      else if (csr.csr_num == TIS_ADDR)
         csr.csr_rvalue = 32'(pending);
      for (int i = 0; i < NUM_TIMERS; i++) begin
         if (csr.csr_num == cfg_addr(i))
            csr.csr_rvalue = cfg[i];
         else if (csr.csr_num == cfg_addr(i) + 14'd1)
            csr.csr_rvalue = cnt[i];
      end
   end

   assign timer_irq = pending & tie;
   assign irq_any   = |timer_irq;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench for csr_timer_bank: one task per feature, inline checks, hand-computed values.
module tb_csr_timer_bank;

   localparam logic [13:0] TCFG0 = 14'h060, TVAL0 = 14'h061, TICLR0 = 14'h062;
   localparam logic [13:0] TCFG1 = 14'h063, TVAL1 = 14'h064, TICLR1 = 14'h065;
   localparam logic [13:0] TCFG2 = 14'h066, TVAL2 = 14'h067;
   localparam logic [13:0] TCFG3 = 14'h069, TVAL3 = 14'h06A;
   localparam logic [13:0] TIE   = 14'h06C, TIS   = 14'h06D, UNMAPPED = 14'h06E;

   logic       clk = 1'b0;
   logic       resetn;
   logic       freeze;
   logic [3:0] timer_irq;
   logic       irq_any;
   int         passed = 0;
   int         total  = 0;

   csr_timer_bank_if bus ();

   csr_timer_bank #(.NUM_TIMERS(4), .CSR_BASE(14'h060)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .csr       (bus.slave),
      .freeze    (freeze),
      .timer_irq (timer_irq),
      .irq_any   (irq_any)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [13:0] a, output logic [31:0] v);
      bus.csr_num = a;
      #1;
      v = bus.csr_rvalue;
   endtask

   task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] d);
      bus.csr_num    = a;
      bus.csr_wmask  = m;
      bus.csr_wvalue = d;
      bus.csr_we     = 1'b1;
      step();
      bus.csr_we     = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rd(TVAL0 + 14'(3 * i), v);
         total++;
         if (v !== 32'hFFFF_FFFF) $display("FAIL reset_tval%0d got %h want ffffffff", i, v);
         else passed++;
      end
      rd(TCFG0, v);
      total++;
      if (v !== 32'd0) $display("FAIL reset_tcfg0 got %h want 0", v); else passed++;
      rd(TIS, v);
      total++;
      if (v !== 32'd0) $display("FAIL reset_tis got %h want 0", v); else passed++;
      rd(TIE, v);
      total++;
      if (v !== 32'd0) $display("FAIL reset_tie got %h want 0", v); else passed++;
      total++;
      if (timer_irq !== 4'd0 || irq_any !== 1'b0)
         $display("FAIL reset_irq got %b/%b want 0000/0", timer_irq, irq_any);
      else passed++;
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      wr(TIE, 32'hFFFF_FFFF, 32'h1);
      wr(TCFG0, 32'hFFFF_FFFF, 32'h15);
      for (int k = 0; k <= 20; k++) begin
         rd(TVAL0, v);
         total++;
         if (v !== 32'(20 - k)) $display("FAIL oneshot_tval k=%0d got %0d want %0d", k, v, 20 - k);
         else passed++;
         total++;
         if (timer_irq[0] !== 1'b0) $display("FAIL oneshot_early_irq k=%0d got %b want 0", k, timer_irq[0]);
         else passed++;
         step();
      end
      for (int k = 0; k < 4; k++) begin
         rd(TVAL0, v);
         total++;
         if (v !== 32'hFFFF_FFFF) $display("FAIL oneshot_idle k=%0d got %h want ffffffff", k, v);
         else passed++;
         total++;
         if (timer_irq[0] !== 1'b1 || irq_any !== 1'b1)
            $display("FAIL oneshot_irq k=%0d got %b/%b want 1/1", k, timer_irq[0], irq_any);
         else passed++;
         step();
      end
      wr(TICLR0, 32'h1, 32'h1);
      rd(TIS, v);
      total++;
      if (v !== 32'd0) $display("FAIL oneshot_clear got %h want 0", v); else passed++;
      rd(TICLR0, v);
      total++;
      if (v !== 32'd0) $display("FAIL ticlr_read got %h want 0", v); else passed++;
   endtask

   task automatic test_periodic();
      logic [31:0] v;
      logic        exp_p;
      wr(TCFG1, 32'hFFFF_FFFF, 32'hB);
      for (int k = 0; k <= 18; k++) begin
         rd(TVAL1, v);
         total++;
         if (v !== 32'(8 - (k % 9))) $display("FAIL periodic_tval k=%0d got %0d want %0d", k, v, 8 - (k % 9));
         else passed++;
         exp_p = ((k >= 9) && (k <= 11)) || (k >= 18);
         rd(TIS, v);
         total++;
         if (v[1] !== exp_p) $display("FAIL periodic_pend k=%0d got %b want %b", k, v[1], exp_p);
         else passed++;
         if (k == 11) begin
            bus.csr_num    = TICLR1;
            bus.csr_wmask  = 32'h1;
            bus.csr_wvalue = 32'h1;
            bus.csr_we     = 1'b1;
         end
         step();
         bus.csr_we = 1'b0;
      end
      wr(TCFG1, 32'hFFFF_FFFF, 32'h0);
      rd(TVAL1, v);
      total++;
      if (v !== 32'd7) $display("FAIL disable_hold got %0d want 7", v); else passed++;
   endtask

   task automatic test_clear_collision();
      logic [31:0] v;
      wr(TICLR1, 32'h1, 32'h1);
      rd(TIS, v);
      total++;
      if (v !== 32'd0) $display("FAIL precollide_tis got %h want 0", v); else passed++;
      wr(TCFG1, 32'hFFFF_FFFF, 32'h1);
      rd(TVAL1, v);
      total++;
      if (v !== 32'd0) $display("FAIL zero_load got %h want 0", v); else passed++;
      wr(TICLR1, 32'h1, 32'h1);
      rd(TIS, v);
      total++;
      if (v !== 32'h2) $display("FAIL collide_tis got %h want 2", v); else passed++;
      rd(TVAL1, v);
      total++;
      if (v !== 32'hFFFF_FFFF) $display("FAIL collide_tval got %h want ffffffff", v); else passed++;
   endtask

   task automatic test_freeze();
      logic [31:0] v;
      wr(TCFG2, 32'hFFFF_FFFF, 32'h41);
      freeze = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         rd(TVAL2, v);
         total++;
         if (v !== 32'd64) $display("FAIL freeze_hold k=%0d got %0d want 64", k, v); else passed++;
      end
      freeze = 1'b0;
      step();
      rd(TVAL2, v);
      total++;
      if (v !== 32'd63) $display("FAIL freeze_release got %0d want 63", v); else passed++;
   endtask

   task automatic test_partial_write();
      logic [31:0] v;
      wr(TCFG3, 32'hFFFF_FFFF, 32'h103);
      repeat (5) step();
      rd(TVAL3, v);
      total++;
      if (v !== 32'd251) $display("FAIL ch3_count got %0d want 251", v); else passed++;
      wr(TCFG3, 32'h1, 32'h0);
      rd(TCFG3, v);
      total++;
      if (v !== 32'h102) $display("FAIL partial_tcfg got %h want 102", v); else passed++;
      repeat (3) step();
      rd(TVAL3, v);
      total++;
      if (v !== 32'd251) $display("FAIL partial_hold got %0d want 251", v); else passed++;
      rd(UNMAPPED, v);
      total++;
      if (v !== 32'd0) $display("FAIL unmapped_read got %h want 0", v); else passed++;
      wr(TVAL3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd(TVAL3, v);
      total++;
      if (v !== 32'd251) $display("FAIL tval_ro got %0d want 251", v); else passed++;
      wr(UNMAPPED, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd(TIE, v);
      total++;
      if (v !== 32'h1) $display("FAIL unmapped_write_tie got %h want 1", v); else passed++;
      rd(TCFG3, v);
      total++;
      if (v !== 32'h102) $display("FAIL unmapped_write_tcfg got %h want 102", v); else passed++;
      wr(TIE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd(TIE, v);
      total++;
      if (v !== 32'hF) $display("FAIL tie_upper got %h want f", v); else passed++;
      total++;
      if (timer_irq !== 4'b0010 || irq_any !== 1'b1)
         $display("FAIL irq_mask got %b/%b want 0010/1", timer_irq, irq_any);
      else passed++;
   endtask

   task automatic test_reset_midcount();
      logic [31:0] v;
      bus.csr_num    = TIE;
      bus.csr_wmask  = 32'hFFFF_FFFF;
      bus.csr_wvalue = 32'hF;
      bus.csr_we     = 1'b1;
      resetn         = 1'b0;
      step();
      bus.csr_we     = 1'b0;
      resetn         = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rd(TVAL0 + 14'(3 * i), v);
         total++;
         if (v !== 32'hFFFF_FFFF) $display("FAIL midreset_tval%0d got %h want ffffffff", i, v);
         else passed++;
      end
      rd(TIS, v);
      total++;
      if (v !== 32'd0) $display("FAIL midreset_tis got %h want 0", v); else passed++;
      rd(TIE, v);
      total++;
      if (v !== 32'd0) $display("FAIL midreset_tie got %h want 0", v); else passed++;
      rd(TCFG2, v);
      total++;
      if (v !== 32'd0) $display("FAIL midreset_tcfg2 got %h want 0", v); else passed++;
      total++;
      if (timer_irq !== 4'd0 || irq_any !== 1'b0)
         $display("FAIL midreset_irq got %b/%b want 0000/0", timer_irq, irq_any);
      else passed++;
   endtask

   initial begin
      resetn         = 1'b0;
      freeze         = 1'b0;
      bus.csr_re     = 1'b1;
      bus.csr_num    = 14'd0;
      bus.csr_we     = 1'b0;
      bus.csr_wmask  = 32'd0;
      bus.csr_wvalue = 32'd0;
      test_reset();
      test_oneshot();
      test_periodic();
      test_clear_collision();
      test_freeze();
      test_partial_write();
      test_reset_midcount();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
